// File: rtl/echo_sensor_if.sv
// Ultrasonic ranger signal bundle: raw echo in, trigger and measurement results out.
interface echo_sensor_if;
  logic        echo;
  logic        trig;
  logic        echo_sig;
  logic        near;
  logic [21:0] echo_cycles;
  logic        meas_valid;

  modport master (
    output echo,
    input  trig, echo_sig, near, echo_cycles, meas_valid
  );

  modport slave (
    input  echo,
    output trig, echo_sig, near, echo_cycles, meas_valid
  );
endinterface

// File: rtl/echo_sensor.sv
// Ultrasonic echo ranger: periodic trigger, echo width measurement with
// timeout, and hysteretic near/far classification with a play pulse on near-entry.
module echo_sensor #(
  parameter int unsigned TRIG_CYC    = 500,
  parameter int unsigned PERIOD_CYC  = 3000000,
  parameter int unsigned TIMEOUT_CYC = 1500000,
  parameter int unsigned NEAR_CYC    = 29000,
  parameter int unsigned FAR_CYC     = 34800
) (
  input  logic         clk,
  input  logic         rst,
  echo_sensor_if.slave bus
);

  typedef enum logic [1:0] {S_TRIG, S_WAIT, S_MEAS, S_HOLD} state_t;

  // Period counter keeps running through WAIT/MEAS, so it must hold a late
  // completion (trigger + two full timeouts) as well as the period itself.
  localparam int unsigned PW = $clog2(PERIOD_CYC + 2 * TIMEOUT_CYC + TRIG_CYC + 4);

  localparam logic [PW-1:0] TRIG_P      = PW'(TRIG_CYC);
  localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIOD_CYC - 1);
  localparam logic [PW-1:0] PCNT_ONE    = PW'(1);
  localparam logic [21:0]   TMO_W       = 22'(TIMEOUT_CYC);
  localparam logic [21:0]   TMO_LAST    = 22'(TIMEOUT_CYC - 1);
  localparam logic [21:0]   NEAR_W      = 22'(NEAR_CYC);
  localparam logic [21:0]   FAR_W       = 22'(FAR_CYC);
  localparam logic [21:0]   W_ONE       = 22'(1);

  state_t        r_state;
  logic [PW-1:0] r_pcnt;
  logic [21:0]   r_width;
  logic          r_sync1;
  logic          r_echo_s;
  logic          r_echo_p;
  logic          r_trig;
  logic          r_echo_sig;
  logic          r_near;
  logic          r_meas_valid;
  logic [21:0]   r_echo_cycles;

  logic          w_rise;
  logic          w_done;
  logic          w_tmo;
  logic [21:0]   w_result;

  // Two-flop synchronizer plus one delayed copy for rise detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1  <= 1'b0;
      r_echo_s <= 1'b0;
      r_echo_p <= 1'b0;
    end else begin
      r_sync1  <= bus.echo;
      r_echo_s <= r_sync1;
      r_echo_p <= r_echo_s;
    end
  end

  assign w_rise = r_echo_s & ~r_echo_p;

  // Decide whether this cycle ends a measurement and what the result is.
  always_comb begin
    w_done = 1'b0;
    w_tmo  = 1'b0;
    unique case (r_state)
      S_WAIT: begin
        if (!w_rise && r_width == TMO_LAST) begin
          w_done = 1'b1;
          w_tmo  = 1'b1;
        end
      end
      S_MEAS: begin
        if (!r_echo_s) begin
          w_done = 1'b1;
        end else if (r_width == TMO_LAST) begin
          w_done = 1'b1;
          w_tmo  = 1'b1;
        end
      end
      default: ;
    endcase
    w_result = w_tmo ? TMO_W : r_width;
  end

  // Trigger/measure/hold sequencer with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_TRIG;
      r_pcnt        <= '0;
      r_width       <= '0;
      r_trig        <= 1'b0;
      r_echo_sig    <= 1'b0;
      r_near        <= 1'b0;
      r_meas_valid  <= 1'b0;
      r_echo_cycles <= '0;
    end else begin
      r_meas_valid <= 1'b0;
      r_echo_sig   <= 1'b0;
      r_pcnt       <= r_pcnt + PCNT_ONE;
      unique case (r_state)
        S_TRIG: begin
          if (r_pcnt < TRIG_P) begin
            r_trig <= 1'b1;
          end else begin
            r_trig  <= 1'b0;
            r_width <= '0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_rise) begin
            r_width <= W_ONE;
            r_state <= S_MEAS;
          end else if (!w_done) begin
            r_width <= r_width + W_ONE;
          end
        end
        S_MEAS: begin
          if (!w_done) r_width <= r_width + W_ONE;
        end
        S_HOLD: begin
          if (r_pcnt >= PERIOD_LAST) begin
            r_pcnt  <= '0;
            r_state <= S_TRIG;
          end
        end
      endcase

      if (w_done) begin
        r_state       <= S_HOLD;
        r_meas_valid  <= 1'b1;
        r_echo_cycles <= w_result;
        if (w_tmo) begin
          r_near <= 1'b0;
        end else if (!r_near && w_result < NEAR_W) begin
          r_near     <= 1'b1;
          r_echo_sig <= 1'b1;
        end else if (r_near && w_result > FAR_W) begin
          r_near <= 1'b0;
        end
      end
    end
  end

  assign bus.trig        = r_trig;
  assign bus.echo_sig    = r_echo_sig;
  assign bus.near        = r_near;
  assign bus.echo_cycles = r_echo_cycles;
  assign bus.meas_valid  = r_meas_valid;

endmodule

// File: tb/tb_echo_sensor.sv
// Bench for echo_sensor: per-period timeline model (trigger window, completion
// cycle, result, near level) checked every cycle, plus literal pin checks.
module tb_echo_sensor;

  localparam int TRIG = 10;
  localparam int PER  = 2000;
  localparam int TMO  = 1000;
  localparam int NEAR = 100;
  localparam int FAR  = 120;
  localparam int BIG  = 32'h3fffffff;

  logic clk = 1'b0;
  logic rst = 1'b1;

  echo_sensor_if bus();

  echo_sensor #(
    .TRIG_CYC   (TRIG),
    .PERIOD_CYC (PER),
    .TIMEOUT_CYC(TMO),
    .NEAR_CYC   (NEAR),
    .FAR_CYC    (FAR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc;
  bit en = 1'b0;

  // Model of the current period: trigger rise cycle, completion cycle, values
  // before and after completion.
  int p_T, p_M, res_old, res_new;
  bit near_old, near_new, sig_new;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic init_model();
    p_T = 1; p_M = BIG;
    res_old = 0; res_new = 0;
    near_old = 1'b0; near_new = 1'b0; sig_new = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Every-cycle comparison against the period model.
  always @(negedge clk) begin
    if (en && !rst) begin
      check("trig",        bus.trig,        32'((cyc >= p_T) && (cyc < p_T + TRIG)));
      check("meas_valid",  bus.meas_valid,  32'(cyc == p_M));
      check("echo_sig",    bus.echo_sig,    32'((cyc == p_M) && sig_new));
      check("near",        bus.near,        32'((cyc >= p_M) ? near_new : near_old));
      check("echo_cycles", bus.echo_cycles, 32'((cyc >= p_M) ? res_new : res_old));
    end
  end

  // One measurement period: off<0 means no echo; otherwise raw echo goes high
  // at cycle p_T+off for len cycles.
  task automatic run_period(input int off, input int len, input bit pin,
                            input int e_res, input bit e_near, input bit e_sig,
                            input bit glitch);
    int s, m, res, gs, gl;
    bit tmo, nn, sg;
    s = p_T + off;
    // Synchronized echo is high from s+2; WAIT covers cycles p_T+TRIG .. p_T+TRIG+TMO-1.
    if (off >= 0 && s + 2 >= p_T + TRIG && s + 2 <= p_T + TRIG + TMO - 1) begin
      res = (len < TMO) ? len : TMO;
      m   = s + 3 + ((len < TMO) ? len : TMO - 1);
      tmo = (len >= TMO);
    end else begin
      res = TMO;
      m   = p_T + TRIG + TMO;
      tmo = 1'b1;
    end
    nn = near_old; sg = 1'b0;
    if (tmo)                          nn = 1'b0;
    else if (!near_old && res < NEAR) begin nn = 1'b1; sg = 1'b1; end
    else if (near_old && res > FAR)   nn = 1'b0;
    p_M = m; res_new = res; near_new = nn; sig_new = sg;
    if (pin && off < 0) check("wait_timeout_offset", 32'(m - p_T), 32'd1010);

    if (off >= 0) begin
      wait_cyc(s);
      bus.echo = 1'b1;
      if (s + len <= m) begin
        wait_cyc(s + len);
        bus.echo = 1'b0;
      end
    end
    wait_cyc(m);
    if (pin) begin
      check("pin_meas_valid",  bus.meas_valid,  32'd1);
      check("pin_echo_cycles", bus.echo_cycles, 32'(e_res));
      check("pin_near",        bus.near,        32'(e_near));
      check("pin_echo_sig",    bus.echo_sig,    32'(e_sig));
    end
    if (off >= 0 && s + len > m) begin
      wait_cyc(s + len);
      bus.echo = 1'b0;
    end
    wait_cyc(m + 1);
    near_old = near_new;
    res_old  = res_new;
    p_T = (p_T + PER > m + 2) ? p_T + PER : m + 2;
    p_M = BIG;
    // Echo activity while holding must be ignored.
    if (glitch) begin
      gs = cyc + 3;
      gl = $urandom_range(1, 40);
      if (gs + gl + 4 < p_T) begin
        wait_cyc(gs);
        bus.echo = 1'b1;
        wait_cyc(gs + gl);
        bus.echo = 1'b0;
      end
    end
  endtask

  typedef struct {
    int off; int len; int res; bit nr; bit sg;
  } dir_t;

  dir_t dirs[14] = '{
    '{20,   80,   80, 1'b1, 1'b1},
    '{20,   80,   80, 1'b1, 1'b0},
    '{30,  110,  110, 1'b1, 1'b0},
    '{30,  120,  120, 1'b1, 1'b0},
    '{30,  121,  121, 1'b0, 1'b0},
    '{-1,    0, 1000, 1'b0, 1'b0},
    '{ 2, 1100, 1000, 1'b0, 1'b0},
    '{20,   80,   80, 1'b1, 1'b1},
    '{20, 1500, 1000, 1'b0, 1'b0},
    '{25,  100,  100, 1'b0, 1'b0},
    '{25,   99,   99, 1'b1, 1'b1},
    '{ 8,   40,   40, 1'b1, 1'b0},
    '{ 7,   40, 1000, 1'b0, 1'b0},
    '{40,   60,   60, 1'b1, 1'b1}
  };

  initial begin
    int s, off, len, k;
    bus.echo = 1'b0;
    rst = 1'b1;
    init_model();
    repeat (3) @(posedge clk);
    #1;
    check("rst_trig",        bus.trig,        32'd0);
    check("rst_echo_sig",    bus.echo_sig,    32'd0);
    check("rst_near",        bus.near,        32'd0);
    check("rst_meas_valid",  bus.meas_valid,  32'd0);
    check("rst_echo_cycles", bus.echo_cycles, 32'd0);

    @(negedge clk);
    #1;
    rst = 1'b0;
    en  = 1'b1;
    wait_cyc(1);
    check("trig_first_edge", bus.trig, 32'd1);
    wait_cyc(10);
    check("trig_c10", bus.trig, 32'd1);
    wait_cyc(11);
    check("trig_c11", bus.trig, 32'd0);

    for (int i = 0; i < 14; i++) begin
      if (i == 1) begin
        wait_cyc(2000);
        check("trig_c2000", bus.trig, 32'd0);
        wait_cyc(2001);
        check("trig_c2001", bus.trig, 32'd1);
      end
      run_period(dirs[i].off, dirs[i].len, 1'b1, dirs[i].res, dirs[i].nr, dirs[i].sg, 1'b0);
    end

    // Reset in the middle of a measurement while near is set.
    s = p_T + 20;
    wait_cyc(s);
    bus.echo = 1'b1;
    wait_cyc(s + 150);
    #2;
    rst = 1'b1;
    #1;
    check("abort_trig",        bus.trig,        32'd0);
    check("abort_near",        bus.near,        32'd0);
    check("abort_echo_cycles", bus.echo_cycles, 32'd0);
    check("abort_meas_valid",  bus.meas_valid,  32'd0);
    check("abort_echo_sig",    bus.echo_sig,    32'd0);
    bus.echo = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_hold_meas_valid", bus.meas_valid, 32'd0);
    check("abort_hold_trig",       bus.trig,       32'd0);
    @(negedge clk);
    #1;
    init_model();
    rst = 1'b0;
    wait_cyc(1);
    check("trig_restart", bus.trig, 32'd1);

    for (int i = 0; i < 15; i++) begin
      k = $urandom_range(0, 9);
      off = (k == 0) ? -1 : $urandom_range(0, 600);
      k = $urandom_range(0, 9);
      if (k < 5)      len = $urandom_range(60, 160);
      else if (k < 9) len = $urandom_range(1, 400);
      else            len = $urandom_range(900, 1100);
      run_period(off, len, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish at cycle %0d, expected completion earlier", cyc);
    $fatal(1);
  end

endmodule

// File: doc/echo_sensor.md
ECHO_SENSOR -- requirements
Module: echo_sensor

Interface
REQ-001 SHALL have parameter TRIG_CYC, default 500, trigger pulse length in clk cycles (10 us at 50 MHz).
REQ-002 SHALL have parameter PERIOD_CYC, default 3000000, measurement period in cycles (60 ms), counted from trig rise.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1500000, echo wait/width timeout and saturation value in cycles.
REQ-004 SHALL have parameter NEAR_CYC, default 29000, echo width below which object is near (~10 cm).
REQ-005 SHALL have parameter FAR_CYC, default 34800, echo width above which object is far (~12 cm); FAR_CYC >= NEAR_CYC.
REQ-006 SHALL have a single clock and an asynchronous, active-high reset: clk input 1 (system clock, 50 MHz, all logic on posedge) and rst input 1 (async active-high reset).
REQ-007 SHALL have port echo, input, 1 bit: raw sensor echo, asynchronous to clk.
REQ-008 SHALL have port trig, output, 1 bit: sensor trigger, registered.
REQ-009 SHALL have port echo_sig, output, 1 bit: one-cycle play pulse to the pet FSM on near-entry.
REQ-010 SHALL have port near, output, 1 bit: hysteretic proximity level.
REQ-011 SHALL have port echo_cycles, output, 22 bits: last measured echo width in cycles.
REQ-012 SHALL have port meas_valid, output, 1 bit: one-cycle pulse when echo_cycles/near update.

Function
REQ-013 SHALL pass echo through a 2-flop synchronizer (echo_s); the rise edge is echo_s=1 with previous echo_s=0.
REQ-014 SHALL implement FSM TRIG -> WAIT -> MEAS -> HOLD -> TRIG, with period counter pcnt cleared on TRIG entry.
REQ-015 SHALL in TRIG hold trig=1 for exactly TRIG_CYC cycles, then enter WAIT with trig=0.
REQ-016 SHALL in WAIT enter MEAS on echo_s rise, loading width counter with 1.
REQ-017 SHALL in WAIT, if no rise within TIMEOUT_CYC cycles of WAIT entry, complete with a timeout result.
REQ-018 SHALL in MEAS increment width each cycle echo_s=1, so the result equals the number of cycles echo_s was high.
REQ-019 SHALL in MEAS complete with a normal result on the first cycle echo_s=0.
REQ-020 SHALL in MEAS complete with a timeout result when width reaches TIMEOUT_CYC.
REQ-021 SHALL on completion enter HOLD, then enter TRIG when pcnt reaches PERIOD_CYC-1, giving a trig rise exactly every PERIOD_CYC cycles.
REQ-022 SHALL on a normal result, the cycle after completion, set echo_cycles=width and pulse meas_valid.
REQ-023 SHALL on a timeout result set echo_cycles=TIMEOUT_CYC, treated as far.
REQ-024 SHALL set near 0->1 only when result < NEAR_CYC; width exactly NEAR_CYC leaves near unchanged.
REQ-025 SHALL set near 1->0 only when result > FAR_CYC; width exactly FAR_CYC leaves near unchanged.
REQ-026 SHALL pulse echo_sig for one cycle, coincident with meas_valid, only on a near 0->1 transition; consecutive near results give no further pulse.
REQ-027 SHALL ignore echo activity in TRIG and HOLD; an echo already high at WAIT entry is not a rise.

Reset
REQ-028 SHALL on rst: trig=0, echo_sig=0, near=0, meas_valid=0, echo_cycles=0, synchronizer=0, counters=0, state=TRIG.
REQ-029 SHALL on rst assertion mid-operation abort immediately, discarding any partial measurement.
REQ-030 SHALL raise trig on the first clk edge after rst deasserts.

Verification
Bench uses TRIG_CYC=10, PERIOD_CYC=2000, TIMEOUT_CYC=1000, NEAR_CYC=100, FAR_CYC=120.
REQ-031 SHALL verify: release rst -> trig high 10 cycles; next rise 2000 cycles later; all other outputs 0.
REQ-032 SHALL verify: echo high 80 cycles after trig -> echo_cycles=80, near=1, echo_sig and meas_valid each one pulse; repeated 80 -> meas_valid only.
REQ-033 SHALL verify hysteresis: near=1, widths 110, 120, 121 -> near stays 1, 1, then clears; no echo_sig.
REQ-034 SHALL verify: no echo -> meas_valid 1000 cycles after WAIT entry, echo_cycles=1000, near=0.
REQ-035 SHALL verify: echo stuck high -> timeout, echo_cycles=1000; echo high 1500 cycles -> echo_cycles=1000, far.
REQ-036 SHALL verify: rst pulsed mid-MEAS -> outputs zero at once, no meas_valid, trig restarts after release.
